adder16_rr_sched: RTL

//  Round-robin scheduler sharing one 16-bit registered adder (17-bit sum) between NUM_REQ requesters.
//  - Accepts one operand pair at a time over valid/ready.
//  - Drives the shared adder and waits out its latency.
//  - Returns the sum, tagged with the requester index, over a valid/ready response port.
//  - Sits between client blocks and the single adder instance.

---
 rtl/adder16_sched_pkg.sv | 36 +++
 rtl/rr_arbiter16.sv | 33 +++
 rtl/adder16_rr_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/adder16_sched_pkg.sv
// Shared types and round-robin pick helper for adder16_rr_sched.
// Optional overflow counter: define ADDER16_SCHED_OVF_CNT_EN.
package adder16_sched_pkg;

  localparam int OPW  = 16;
  localparam int SUMW = 17;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

  // First set bit of req searching upward from last+1, wrapping at n.
  function automatic logic [2:0] rr_pick(
    input logic [15:0] req,
    input logic [2:0]  last,
    input logic [3:0]  n
  );
    logic [2:0] g;
    logic       found;
    logic [3:0] s;
    g     = '0;
    found = 1'b0;
    for (logic [3:0] k = 4'd1; k <= 4'd8; k++) begin
      s = {1'b0, last} + k;
      if (s >= n) s = s - n;
      if (k <= n && !found && req[s]) begin
        g     = s[2:0];
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter16.sv
// Combinational round-robin picker: request vector plus last
// grant in, one-hot grant and grant index out.
module rr_arbiter16
  import adder16_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic               any,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  logic [15:0] req16;
  logic [2:0]  last3;
  logic [2:0]  pick;

  always_comb begin
    req16 = '0;
    req16[NUM_REQ-1:0] = req;
    last3 = '0;
    last3[IDW-1:0] = last_grant;
    pick = rr_pick(req16, last3, 4'(NUM_REQ));
    any = |req;
    grant_idx = pick[IDW-1:0];
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant[i] = any && (pick == i[2:0]);
  end

endmodule

// File: rtl/adder16_rr_sched.sv
// Round-robin scheduler sharing one registered 16-bit adder.
// Optional ovf_cnt port: define ADDER16_SCHED_OVF_CNT_EN.
module adder16_rr_sched
  import adder16_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 1,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [SUMW-1:0]        rsp_sum,
  output logic                   add_rst_n,
  output logic [OPW-1:0]         add_a,
  output logic [OPW-1:0]         add_b,
  input  logic [SUMW-1:0]        add_sum
`ifdef ADDER16_SCHED_OVF_CNT_EN
  ,
  output logic [15:0]            ovf_cnt
`endif
);

  localparam int LCW =
    (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

  sched_state_t state, state_nxt;

  logic [IDW-1:0]     last_grant;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any;
  logic [OPW-1:0]     op_a, op_b;
  logic [OPW-1:0]     sel_a, sel_b;
  logic [IDW-1:0]     op_id;
  logic [LCW-1:0]     lat_cnt;
  logic               cool;
  logic               accept, capture, done;

  rr_arbiter16 #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .any        (any),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*OPW +: OPW];
        sel_b = req_b[i*OPW +: OPW];
      end
    end
  end

  // cool blocks a grant in the cycle right after a response handshake
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any && !cool) begin
          req_ready = grant;
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(NUM_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      lat_cnt    <= '0;
      rsp_sum    <= '0;
      rsp_id     <= '0;
      cool       <= 1'b0;
    end else begin
      cool <= done;
      if (accept) begin
        op_a       <= sel_a;
        op_b       <= sel_b;
        op_id      <= grant_idx;
        last_grant <= grant_idx;
        lat_cnt    <= LCW'(ADD_LAT);
      end
      if (state == EXEC && lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;
      if (capture) begin
        rsp_sum <= add_sum;
        rsp_id  <= op_id;
      end
    end
  end

`ifdef ADDER16_SCHED_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      ovf_cnt <= '0;
    else if (done && rsp_sum[SUMW-1] && ovf_cnt != 16'hFFFF)
      ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

  assign rsp_valid = (state == RESP);
  assign add_rst_n = ~rst;
  assign add_a     = op_a;
  assign add_b     = op_b;

endmodule
